// File: rtl/fifo_skew_control_if.sv
// Handshake bundle between the top-level controller and the skewed FIFO-enable sequencer.
// The stall signal exists only when FIFO_SKEW_STALL_EN is defined.
interface fifo_skew_control_if #(
    parameter int unsigned LANES = 16,
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             reverse;
`ifdef FIFO_SKEW_STALL_EN
    logic             stall;
`endif
    logic [LANES-1:0] fifo_en;
    logic             busy;
    logic             done;

`ifdef FIFO_SKEW_STALL_EN
    modport master (output start, len, reverse, stall, input fifo_en, busy, done);
    modport slave  (input start, len, reverse, stall, output fifo_en, busy, done);
`else
    modport master (output start, len, reverse, input fifo_en, busy, done);
    modport slave  (input start, len, reverse, output fifo_en, busy, done);
`endif
endinterface

// File: rtl/fifo_skew_control.sv
// Skewed-enable sequencer: lane k is enabled for len cycles starting k cycles after the leading lane.
// Optional stall input is compiled in with FIFO_SKEW_STALL_EN.
module fifo_skew_control #(
    parameter int unsigned LANES = 16,
    parameter int unsigned LEN_W = 8
) (
    input logic               clk,
    input logic               reset,
    fifo_skew_control_if.slave bus
);
    localparam int unsigned TW = LEN_W + $clog2(LANES) + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    t_q, t_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             rev_q, rev_d;
    logic [LANES-1:0] en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stall;
    logic             last_t;
    logic             start_ok;

`ifdef FIFO_SKEW_STALL_EN
    assign stall = bus.stall;
`else
    assign stall = 1'b0;
`endif

    // t_q indexes the pattern currently on fifo_en; the last one is LANES+len-2.
    assign last_t   = (t_q == TW'(LANES) + TW'(len_q) - TW'(2));
    assign start_ok = bus.start && (bus.len != '0);

    function automatic logic [LANES-1:0] lane_pattern(input logic [TW-1:0]    t,
                                                      input logic [LEN_W-1:0] l,
                                                      input logic             r);
        logic [LANES-1:0] p;
        logic [TW-1:0]    k;
        p = '0;
        for (int i = 0; i < LANES; i++) begin
            k    = r ? TW'(LANES - 1 - i) : TW'(i);
            p[i] = (k <= t) && (t < k + TW'(l));
        end
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun:   if (!stall && last_t) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        t_d    = t_q;
        len_d  = len_q;
        rev_d  = rev_q;
        en_d   = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    len_d  = bus.len;
                    rev_d  = bus.reverse;
                    t_d    = '0;
                    en_d   = lane_pattern('0, bus.len, bus.reverse);
                    busy_d = 1'b1;
                end else if (bus.start) begin
                    // Zero-length request completes immediately without running.
                    done_d = 1'b1;
                end
            end
            StRun: begin
                if (stall) begin
                    busy_d = 1'b1;
                end else if (last_t) begin
                    done_d = 1'b1;
                    t_d    = '0;
                end else begin
                    t_d    = t_q + TW'(1);
                    en_d   = lane_pattern(t_q + TW'(1), len_q, rev_q);
                    busy_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q    <= '0;
            len_q  <= '0;
            rev_q  <= 1'b0;
            en_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            len_q  <= len_d;
            rev_q  <= rev_d;
            en_q   <= en_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.fifo_en = en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_fifo_skew_control.sv
// Directed bench for fifo_skew_control with a 4-lane and a 16-lane instance.
// Stall scenarios are exercised when FIFO_SKEW_STALL_EN is defined.
module tb_fifo_skew_control;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [3:0] exp_q[$];

    fifo_skew_control_if #(.LANES(4),  .LEN_W(8)) bus4 ();
    fifo_skew_control_if #(.LANES(16), .LEN_W(8)) bus16 ();

    fifo_skew_control #(.LANES(4), .LEN_W(8)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    fifo_skew_control #(.LANES(16), .LEN_W(8)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed value packs {done, busy, fifo_en} of the 4-lane instance.
    task automatic check(input string tag, input logic [31:0] exp);
        logic [31:0] obs;
        obs = {26'b0, bus4.done, bus4.busy, bus4.fifo_en};
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed {done,busy,en}=%0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic d, input logic b, input logic [3:0] en);
        return {26'b0, d, b, en};
    endfunction

    // Walks exp_q as busy patterns, then expects the done cycle.
    task automatic play(input string tag);
        foreach (exp_q[i]) begin
            check($sformatf("%s_t%0d", tag, i), pk(1'b0, 1'b1, exp_q[i]));
            tick();
        end
        check($sformatf("%s_done", tag), pk(1'b1, 1'b0, 4'h0));
    endtask

    initial begin
        int nz;
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus4.start    = 1'b0;
        bus4.len      = '0;
        bus4.reverse  = 1'b0;
        bus16.start   = 1'b0;
        bus16.len     = '0;
        bus16.reverse = 1'b0;
`ifdef FIFO_SKEW_STALL_EN
        bus4.stall    = 1'b0;
        bus16.stall   = 1'b0;
`endif
        // 1. reset and idle
        tick();
        tick();
        reset = 1'b0;
        check("reset", pk(1'b0, 1'b0, 4'h0));
        tick();
        check("idle0", pk(1'b0, 1'b0, 4'h0));
        tick();
        check("idle1", pk(1'b0, 1'b0, 4'h0));

        // 2. len=2 forward
        bus4.start = 1'b1; bus4.len = 8'd2; bus4.reverse = 1'b0;
        tick();
        bus4.start = 1'b0;
        exp_q = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8};
        play("fwd2");
        tick();
        check("fwd2_after", pk(1'b0, 1'b0, 4'h0));

        // 3. len=1 reverse, restart on the done cycle
        bus4.start = 1'b1; bus4.len = 8'd1; bus4.reverse = 1'b1;
        tick();
        bus4.start = 1'b0;
        exp_q = '{4'h8, 4'h4, 4'h2, 4'h1};
        play("rev1a");
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        play("rev1b");
        tick();
        check("rev1_after", pk(1'b0, 1'b0, 4'h0));

        // 4. len=0 then start ignored while busy
        bus4.start = 1'b1; bus4.len = 8'd0; bus4.reverse = 1'b0;
        tick();
        bus4.start = 1'b0;
        check("len0_done", pk(1'b1, 1'b0, 4'h0));
        tick();
        check("len0_after", pk(1'b0, 1'b0, 4'h0));
        bus4.start = 1'b1; bus4.len = 8'd2; bus4.reverse = 1'b0;
        tick();
        bus4.start = 1'b0;
        exp_q = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8};
        foreach (exp_q[i]) begin
            check($sformatf("ign_t%0d", i), pk(1'b0, 1'b1, exp_q[i]));
            bus4.start   = (i == 1);
            bus4.len     = (i == 1) ? 8'd5 : 8'd2;
            bus4.reverse = (i == 1);
            tick();
        end
        bus4.start = 1'b0;
        check("ign_done", pk(1'b1, 1'b0, 4'h0));
        tick();

        // 5. reset mid-sequence, then a fresh full run
        bus4.start = 1'b1; bus4.len = 8'd3; bus4.reverse = 1'b0;
        tick();
        bus4.start = 1'b0;
        check("abort_t0", pk(1'b0, 1'b1, 4'h1));
        tick();
        check("abort_t1", pk(1'b0, 1'b1, 4'h3));
        tick();
        check("abort_t2", pk(1'b0, 1'b1, 4'h7));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_rst", pk(1'b0, 1'b0, 4'h0));
        tick();
        check("abort_nodone", pk(1'b0, 1'b0, 4'h0));
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        exp_q = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
        play("len3");
        tick();

`ifdef FIFO_SKEW_STALL_EN
        // 6. stall for two cycles after the second pattern
        bus4.start = 1'b1; bus4.len = 8'd2; bus4.reverse = 1'b0;
        tick();
        bus4.start = 1'b0;
        check("stl_t0", pk(1'b0, 1'b1, 4'h1));
        tick();
        check("stl_t1", pk(1'b0, 1'b1, 4'h3));
        bus4.stall = 1'b1;
        tick();
        check("stl_h0", pk(1'b0, 1'b1, 4'h0));
        tick();
        check("stl_h1", pk(1'b0, 1'b1, 4'h0));
        bus4.stall = 1'b0;
        tick();
        exp_q = '{4'h6, 4'hC, 4'h8};
        play("stl_res");
        bus4.stall = 1'b1;
        tick();
        check("stl_idle", pk(1'b0, 1'b0, 4'h0));
        bus4.stall = 1'b0;
        tick();
`endif

        // 16 lanes, len=16, forward
        bus16.start = 1'b1; bus16.len = 8'd16; bus16.reverse = 1'b0;
        tick();
        bus16.start = 1'b0;
        nz = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0)  check16("l16_t0", {16'b0, bus16.fifo_en}, 32'h0001);
            if (c == 15) check16("l16_t15", {16'b0, bus16.fifo_en}, 32'hFFFF);
            if (c == 30) check16("l16_t30", {16'b0, bus16.fifo_en}, 32'h8000);
            if (c == 31) check16("l16_done", {30'b0, bus16.done, bus16.busy}, 32'h2);
            if (bus16.fifo_en != '0) nz++;
            tick();
        end
        check16("l16_count", nz, 32'd31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
